// File: rtl/dma_pkg.sv
// Shared types and AXI encodings for the DMA copy engine.
// AXI width macros fall back to 32-bit address/data, 4-bit ID and 8-bit length when the shared define file is absent.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4,
        ST_WRESP = 3'd5,
        ST_DONE  = 3'd6
    } dma_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    function automatic logic [31:0] chunk_words(input logic [31:0] rem, input logic [31:0] max_burst);
        return (rem < max_burst) ? rem : max_burst;
    endfunction

endpackage

// File: rtl/dma_burst_buf.sv
// Burst staging buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; every word is written before it is read.
module dma_burst_buf
    import dma_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             ACLK,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH];

    // capture one read beat per accepted R handshake
    always_ff @(posedge ACLK) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/dma_engine.sv
// AXI master copying DMALEN words from DMASRC to DMADST in INCR bursts of up to MAX_BURST beats.
// Define DMA_RESP_CHK_EN to flag non-OKAY responses on DMA_ERR and stop after the failing chunk.
module dma_engine
    import dma_pkg::*;
#(
    parameter int                      MAX_BURST = 16,
    parameter logic [`AXI_ID_BITS-1:0] M_ID      = {`AXI_ID_BITS{1'b0}}
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        DMAEN,
    input  logic [31:0]                 DMASRC,
    input  logic [31:0]                 DMADST,
    input  logic [31:0]                 DMALEN,
    output logic [`AXI_ID_BITS-1:0]     M_ARID,
    output logic [`AXI_ADDR_BITS-1:0]   M_ARAddr,
    output logic [`AXI_LEN_BITS-1:0]    M_ARLen,
    output logic [2:0]                  M_ARSize,
    output logic [1:0]                  M_ARBurst,
    output logic                        M_ARValid,
    input  logic                        M_ARReady,
    input  logic [`AXI_ID_BITS-1:0]     M_RID,
    input  logic [`AXI_DATA_BITS-1:0]   M_RData,
    input  logic [`AXI_RESP_BITS-1:0]   M_RResp,
    input  logic                        M_RLast,
    input  logic                        M_RValid,
    output logic                        M_RReady,
    output logic [`AXI_ID_BITS-1:0]     M_AWID,
    output logic [`AXI_ADDR_BITS-1:0]   M_AWAddr,
    output logic [`AXI_LEN_BITS-1:0]    M_AWLen,
    output logic [2:0]                  M_AWSize,
    output logic [1:0]                  M_AWBurst,
    output logic                        M_AWValid,
    input  logic                        M_AWReady,
    output logic [`AXI_DATA_BITS-1:0]   M_WData,
    output logic [3:0]                  M_WStrb,
    output logic                        M_WLast,
    output logic                        M_WValid,
    input  logic                        M_WReady,
    input  logic [`AXI_ID_BITS-1:0]     M_BID,
    input  logic [`AXI_RESP_BITS-1:0]   M_BResp,
    input  logic                        M_BValid,
    output logic                        M_BReady,
    output logic                        DMA_INTR,
    output logic                        DMA_ERR
);

    localparam int               IDX_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int               CNT_W     = IDX_W + 1;
    localparam int               LEN_W     = `AXI_LEN_BITS;
    localparam logic [31:0]      MAX_WORDS = 32'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BURST);

    dma_state_t        state_r;
    logic [31:0]       src_r, dst_r, rem_r, n_r;
    logic [LEN_W-1:0]  len_m1_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              arvalid_r, rready_r, awvalid_r, wvalid_r, wlast_r, bready_r, intr_r, err_r;

    logic              buf_we_s, rd_err_s, wr_err_s;
    logic [31:0]       start_n_s, rem_next_s, next_n_s, buf_rdata_s;
    logic [LEN_W-1:0]  start_len_s, next_len_s;
    logic              unused_s;

    // chunk sizing and response classification
    always_comb begin
        buf_we_s    = (state_r == ST_RDATA) && M_RValid && (cnt_r < CNT_MAX);
        start_n_s   = chunk_words(DMALEN, MAX_WORDS);
        start_len_s = LEN_W'(start_n_s - 32'd1);
        rem_next_s  = rem_r - n_r;
        next_n_s    = chunk_words(rem_next_s, MAX_WORDS);
        next_len_s  = LEN_W'(next_n_s - 32'd1);
`ifdef DMA_RESP_CHK_EN
        rd_err_s    = (state_r == ST_RDATA) && M_RValid && (M_RResp != RESP_OKAY);
        wr_err_s    = (state_r == ST_WRESP) && M_BValid && (M_BResp != RESP_OKAY);
`else
        rd_err_s    = 1'b0;
        wr_err_s    = 1'b0;
`endif
    end

    // transfer sequencer: one outstanding transaction, read phase then write phase per chunk
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r   <= ST_IDLE;
            src_r     <= 32'd0;
            dst_r     <= 32'd0;
            rem_r     <= 32'd0;
            n_r       <= 32'd0;
            len_m1_r  <= {LEN_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            wlast_r   <= 1'b0;
            bready_r  <= 1'b0;
            intr_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (DMAEN) begin
                        src_r    <= DMASRC;
                        dst_r    <= DMADST;
                        rem_r    <= DMALEN;
                        n_r      <= start_n_s;
                        len_m1_r <= start_len_s;
                        err_r    <= 1'b0;
                        if (DMALEN == 32'd0) begin
                            intr_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= ST_RADDR;
                        end
                    end
                end
                ST_RADDR: begin
                    if (M_ARReady) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (M_RValid) begin
                        if (rd_err_s) begin
                            err_r <= 1'b1;
                        end
                        if (cnt_r < CNT_MAX) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                        // the slave's RLast ends the read phase regardless of the beat count
                        if (M_RLast) begin
                            rready_r  <= 1'b0;
                            cnt_r     <= {CNT_W{1'b0}};
                            awvalid_r <= 1'b1;
                            state_r   <= ST_WADDR;
                        end
                    end
                end
                ST_WADDR: begin
                    if (M_AWReady) begin
                        awvalid_r <= 1'b0;
                        wvalid_r  <= 1'b1;
                        wlast_r   <= (len_m1_r == {LEN_W{1'b0}});
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (M_WReady) begin
                        if (wlast_r) begin
                            wvalid_r <= 1'b0;
                            wlast_r  <= 1'b0;
                            bready_r <= 1'b1;
                            state_r  <= ST_WRESP;
                        end else begin
                            cnt_r   <= cnt_r + CNT_W'(1);
                            wlast_r <= ((32'(cnt_r) + 32'd2) == n_r);
                        end
                    end
                end
                ST_WRESP: begin
                    if (M_BValid) begin
                        bready_r <= 1'b0;
                        src_r    <= src_r + (n_r << 2);
                        dst_r    <= dst_r + (n_r << 2);
                        rem_r    <= rem_next_s;
                        if (wr_err_s) begin
                            err_r <= 1'b1;
                        end
                        if ((rem_next_s == 32'd0) || err_r || wr_err_s) begin
                            intr_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            n_r       <= next_n_s;
                            len_m1_r  <= next_len_s;
                            arvalid_r <= 1'b1;
                            state_r   <= ST_RADDR;
                        end
                    end
                end
                ST_DONE: begin
                    if (!DMAEN) begin
                        intr_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    wlast_r   <= 1'b0;
                    bready_r  <= 1'b0;
                    intr_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    dma_burst_buf #(
        .DEPTH (MAX_BURST),
        .IDX_W (IDX_W)
    ) u_buf (
        .ACLK  (ACLK),
        .we    (buf_we_s),
        .waddr (cnt_r[IDX_W-1:0]),
        .wdata (M_RData),
        .raddr (cnt_r[IDX_W-1:0]),
        .rdata (buf_rdata_s)
    );

    assign M_ARID    = M_ID;
    assign M_ARAddr  = src_r;
    assign M_ARLen   = len_m1_r;
    assign M_ARSize  = AXI_SIZE_WORD;
    assign M_ARBurst = AXI_BURST_INCR;
    assign M_ARValid = arvalid_r;
    assign M_RReady  = rready_r;
    assign M_AWID    = M_ID;
    assign M_AWAddr  = dst_r;
    assign M_AWLen   = len_m1_r;
    assign M_AWSize  = AXI_SIZE_WORD;
    assign M_AWBurst = AXI_BURST_INCR;
    assign M_AWValid = awvalid_r;
    assign M_WData   = buf_rdata_s;
    assign M_WStrb   = 4'hF;
    assign M_WLast   = wlast_r;
    assign M_WValid  = wvalid_r;
    assign M_BReady  = bready_r;
    assign DMA_INTR  = intr_r;
`ifdef DMA_RESP_CHK_EN
    assign DMA_ERR   = err_r;
`else
    assign DMA_ERR   = 1'b0;
`endif

    // IDs are single-master constants and responses only matter with checking enabled
    assign unused_s = ^{M_RID, M_BID, M_RResp, M_BResp};

endmodule
